// File: rtl/serial_parity_frame_rx_if.sv
// Handshake bundle between the serial frame receiver and its consumer:
// the serial line in, recovered nibble/parity and status strobes out.
interface serial_parity_frame_rx_if;
  logic       rx;
  logic [3:0] data;
  logic       p;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (output rx, input data, input p, input valid, input frame_err, input busy);
  modport slave  (input rx, output data, output p, output valid, output frame_err, output busy);
endinterface

// File: rtl/serial_parity_frame_rx.sv
// One-wire frame receiver: start, 4 data bits LSB first, parity, stop.
// Recovers nibble + parity for a downstream odd-parity checker; flags stop-bit errors.
module serial_parity_frame_rx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  serial_parity_frame_rx_if.slave   bus
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    bit_cnt;
  logic [3:0]    shreg;
  logic          par;
  logic          rx_meta_p0;
  logic          rx_s;
  logic [3:0]    data_r;
  logic          p_r;
  logic          valid_r;
  logic          frame_err_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      rx_meta_p0  <= 1'b1;
      rx_s        <= 1'b1;
      data_r      <= '0;
      p_r         <= 1'b0;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      // Synchroniser stage: rx -> rx_meta_p0 -> rx_s
      rx_meta_p0  <= bus.rx;
      rx_s        <= rx_meta_p0;
      valid_r     <= 1'b0;
      frame_err_r <= 1'b0;

      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          // Mid-bit check rejects glitches shorter than half a bit.
          if (cnt == CW'(HALF - 1)) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[3:1]};
            if (bit_cnt == 2'd3) begin
              bit_cnt <= '0;
              state   <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            par   <= rx_s;
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CW'(CLKS_PER_BIT - 1)) begin
            cnt   <= '0;
            state <= IDLE;
            if (rx_s) begin
              data_r  <= shreg;
              p_r     <= par;
              valid_r <= 1'b1;
            end else begin
              frame_err_r <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.data      = data_r;
  assign bus.p         = p_r;
  assign bus.valid     = valid_r;
  assign bus.frame_err = frame_err_r;
  assign bus.busy      = (state != IDLE);

endmodule
